// File: rtl/column_demux_pkg.sv
// Shared types and helpers for the column spike demultiplexer: slot encoding,
// slot length and the "no spike" marker derived from the gamma cycle length.
package column_demux_pkg;

   function automatic int unsigned slot_length(input int unsigned g);
      return g / 2;
   endfunction

   // A spike can land at offsets 0..SLOT_LENGTH-1, so SLOT_LENGTH itself is free as a marker.
   function automatic int unsigned no_spike(input int unsigned g);
      return slot_length(g);
   endfunction

   typedef enum logic {
      SLOT_NET1 = 1'b0,
      SLOT_NET2 = 1'b1
   } slot_e;

   localparam int unsigned DEFAULT_GAMMA_CYCLE_LENGTH = 18;
   localparam int unsigned DEFAULT_TW = $clog2(slot_length(DEFAULT_GAMMA_CYCLE_LENGTH) + 1);

   typedef logic [DEFAULT_TW-1:0] spike_time_t;

endpackage

// File: rtl/column_spike_demux_gamma_phase_tracker.sv
// Follows the gamma phase from grst rising edges: running flag, cycle counter,
// slot/offset decode and strobes for the last clock and for a misaligned restart.
module gamma_phase_tracker
   import column_demux_pkg::*;
#(
   parameter  int unsigned GAMMA_CYCLE_LENGTH = 18,
   localparam int unsigned SLOT_LENGTH        = slot_length(GAMMA_CYCLE_LENGTH),
   localparam int unsigned TW                 = $clog2(SLOT_LENGTH + 1),
   localparam int unsigned CW                 = $clog2(GAMMA_CYCLE_LENGTH)
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          grst,
   output logic          running,
   output slot_e         slot,
   output logic [TW-1:0] offset,
   output logic          last_cycle,
   output logic          misalign
);

   localparam logic [CW-1:0] LAST     = CW'(GAMMA_CYCLE_LENGTH - 1);
   localparam logic [CW-1:0] SLOT_LEN = CW'(SLOT_LENGTH);

   logic          grst_q;
   logic          gamma_start;
   logic [CW-1:0] counter;

   assign gamma_start = grst & ~grst_q;

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         grst_q  <= 1'b0;
         running <= 1'b0;
         counter <= '0;
      end else begin
         grst_q <= grst;
         if (gamma_start) begin
            counter <= '0;
            running <= 1'b1;
         end else if (running) begin
            counter <= (counter == LAST) ? '0 : counter + 1'b1;
         end
      end
   end

   assign slot       = (counter >= SLOT_LEN) ? SLOT_NET2 : SLOT_NET1;
   assign offset     = TW'((slot == SLOT_NET2) ? counter - SLOT_LEN : counter);
   assign last_cycle = running && (counter == LAST);
   // A restart on the final clock is just an early-announced wrap, so it is not an error.
   assign misalign   = gamma_start && running && (counter != LAST);

endmodule

// File: rtl/column_spike_demux.sv
// Splits the time-shared column spike bus into per-network streams and publishes
// each neuron's first-spike offset per network slot once every gamma cycle.
module column_spike_demux
   import column_demux_pkg::*;
#(
   parameter  int unsigned Q                  = 2,
   parameter  int unsigned GAMMA_CYCLE_LENGTH = 18,
   localparam int unsigned SLOT_LENGTH        = slot_length(GAMMA_CYCLE_LENGTH),
   localparam int unsigned TW                 = $clog2(SLOT_LENGTH + 1)
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 grst,
   input  logic [Q-1:0]         col_spikes,
   output logic [Q-1:0]         output_spikes1,
   output logic [Q-1:0]         output_spikes2,
   output logic [Q-1:0][TW-1:0] spike_time1,
   output logic [Q-1:0][TW-1:0] spike_time2,
   output logic [Q-1:0]         hit1,
   output logic [Q-1:0]         hit2,
   output logic                 result_valid,
   output logic                 align_err
);

   localparam logic [TW-1:0] NO_SPIKE = TW'(no_spike(GAMMA_CYCLE_LENGTH));

   typedef logic [TW-1:0] stime_t;

   logic          running;
   slot_e         slot;
   logic [TW-1:0] offset;
   logic          last_cycle;
   logic          misalign;

   logic [Q-1:0]          prev;
   logic [Q-1:0]          event_v;
   logic [1:0][Q-1:0]     cap_hit;
   stime_t [1:0][Q-1:0]   cap_time;
   logic [1:0][Q-1:0]     fin_hit;
   stime_t [1:0][Q-1:0]   fin_time;

   gamma_phase_tracker #(
      .GAMMA_CYCLE_LENGTH(GAMMA_CYCLE_LENGTH)
   ) u_tracker (
      .clk        (clk),
      .rstb       (rstb),
      .grst       (grst),
      .running    (running),
      .slot       (slot),
      .offset     (offset),
      .last_cycle (last_cycle),
      .misalign   (misalign)
   );

   // A level already high at slot start counts as an event at offset 0.
   assign event_v = running ? (col_spikes & (~prev | {Q{offset == '0}})) : '0;

   // Capture state as it would stand after this edge; used both to capture and to publish.
   always_comb begin
      fin_hit  = cap_hit;
      fin_time = cap_time;
      for (int unsigned s = 0; s < 2; s++) begin
         for (int unsigned q = 0; q < Q; q++) begin
            if (cap_hit[s][q]) begin
               fin_time[s][q] = cap_time[s][q];
            end else if (event_v[q] && ((s == 1) == (slot == SLOT_NET2))) begin
               fin_hit[s][q]  = 1'b1;
               fin_time[s][q] = offset;
            end else begin
               fin_time[s][q] = NO_SPIKE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         prev           <= '0;
         cap_hit        <= '0;
         cap_time       <= '0;
         output_spikes1 <= '0;
         output_spikes2 <= '0;
         spike_time1    <= {Q{NO_SPIKE}};
         spike_time2    <= {Q{NO_SPIKE}};
         hit1           <= '0;
         hit2           <= '0;
         result_valid   <= 1'b0;
         align_err      <= 1'b0;
      end else begin
         prev           <= col_spikes;
         output_spikes1 <= (running && slot == SLOT_NET1) ? col_spikes : '0;
         output_spikes2 <= (running && slot == SLOT_NET2) ? col_spikes : '0;
         result_valid   <= last_cycle;
         if (misalign) begin
            align_err <= 1'b1;
            cap_hit   <= '0;
            cap_time  <= '0;
         end else if (last_cycle) begin
            spike_time1 <= fin_time[0];
            spike_time2 <= fin_time[1];
            hit1        <= fin_hit[0];
            hit2        <= fin_hit[1];
            cap_hit     <= '0;
            cap_time    <= '0;
         end else if (running) begin
            cap_hit  <= fin_hit;
            cap_time <= fin_time;
         end
      end
   end

endmodule

// File: tb/tb_column_spike_demux.sv
// Drives whole gamma cycles from per-counter spike patterns and checks streams
// and published first-spike results against a scoreboard of expected records.
module tb_column_spike_demux;

   localparam int unsigned Q  = 2;
   localparam int unsigned G  = 18;
   localparam int unsigned SL = 9;
   localparam int unsigned TW = 4;

   logic                 clk = 1'b0;
   logic                 rstb;
   logic                 grst;
   logic [Q-1:0]         col_spikes;
   logic [Q-1:0]         output_spikes1;
   logic [Q-1:0]         output_spikes2;
   logic [Q-1:0][TW-1:0] spike_time1;
   logic [Q-1:0][TW-1:0] spike_time2;
   logic [Q-1:0]         hit1;
   logic [Q-1:0]         hit2;
   logic                 result_valid;
   logic                 align_err;

   column_spike_demux #(
      .Q                  (Q),
      .GAMMA_CYCLE_LENGTH (G)
   ) dut (
      .clk            (clk),
      .rstb           (rstb),
      .grst           (grst),
      .col_spikes     (col_spikes),
      .output_spikes1 (output_spikes1),
      .output_spikes2 (output_spikes2),
      .spike_time1    (spike_time1),
      .spike_time2    (spike_time2),
      .hit1           (hit1),
      .hit2           (hit2),
      .result_valid   (result_valid),
      .align_err      (align_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [Q*TW-1:0] t1;
      logic [Q*TW-1:0] t2;
      logic [Q-1:0]    h1;
      logic [Q-1:0]    h2;
   } res_t;

   res_t         sb[$];
   logic [Q-1:0] pat[G];
   int unsigned  n_checks = 0;
   int unsigned  n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pat();
      for (int unsigned c = 0; c < G; c++) pat[c] = '0;
   endtask

   task automatic pulse(input int unsigned q, input int unsigned lo, input int unsigned hi);
      for (int unsigned c = lo; c <= hi; c++) pat[c][q] = 1'b1;
   endtask

   task automatic rand_pat();
      for (int unsigned c = 0; c < G; c++) pat[c] = Q'($urandom);
   endtask

   task automatic push(input logic [7:0] t1, input logic [1:0] h1,
                       input logic [7:0] t2, input logic [1:0] h2);
      res_t r;
      r.t1 = t1; r.h1 = h1; r.t2 = t2; r.h2 = h2;
      sb.push_back(r);
   endtask

   // First high sample inside a slot is the first event of that slot.
   task automatic push_model();
      res_t r;
      r.t1 = 8'h99; r.t2 = 8'h99; r.h1 = '0; r.h2 = '0;
      for (int unsigned q = 0; q < Q; q++) begin
         for (int c = int'(SL) - 1; c >= 0; c--) begin
            if (pat[c][q]) begin r.t1[q*TW +: TW] = TW'(c); r.h1[q] = 1'b1; end
            if (pat[c+int'(SL)][q]) begin r.t2[q*TW +: TW] = TW'(c); r.h2[q] = 1'b1; end
         end
      end
      sb.push_back(r);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_os1"}, output_spikes1, '0);
      check({tag, "_os2"}, output_spikes2, '0);
      check({tag, "_st1"}, spike_time1, 8'h99);
      check({tag, "_st2"}, spike_time2, 8'h99);
      check({tag, "_hits"}, {hit2, hit1}, '0);
      check({tag, "_rv"}, result_valid, 1'b0);
      check({tag, "_aerr"}, align_err, 1'b0);
   endtask

   // mode 0: full cycle; mode 1: grst edge sampled at counter stop_at; mode 2: reset during counter stop_at
   task automatic run_cycle(input bit start, input int unsigned mode, input int unsigned stop_at);
      if (start) begin
         grst = 1'b1;
         step();
         grst = 1'b0;
      end
      for (int unsigned c = 0; c < G; c++) begin
         if (mode != 0 && c == stop_at) begin
            if (mode == 1) begin
               grst       = 1'b1;
               col_spikes = pat[c];
               step();
               grst       = 1'b0;
            end else begin
               #2 rstb = 1'b1;
               #1 check_reset_state("midreset");
               @(negedge clk);
               rstb = 1'b0;
            end
            return;
         end
         col_spikes = pat[c];
         step();
         check("stream1", output_spikes1, (c < SL) ? pat[c] : '0);
         check("stream2", output_spikes2, (c >= SL) ? pat[c] : '0);
      end
      check("result_valid", result_valid, 1'b1);
   endtask

   always @(negedge clk) begin
      if (result_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_publish", result_valid, 1'b0);
         end else begin
            res_t e;
            e = sb.pop_front();
            check("spike_time1", spike_time1, e.t1);
            check("spike_time2", spike_time2, e.t2);
            check("hit1", hit1, e.h1);
            check("hit2", hit2, e.h2);
         end
      end
   end

   initial begin
      rstb       = 1'b1;
      grst       = 1'b0;
      col_spikes = '0;
      repeat (2) @(posedge clk);
      #1 check_reset_state("reset");
      @(negedge clk);
      rstb       = 1'b0;
      col_spikes = 2'b11;
      for (int unsigned i = 0; i < 6; i++) begin
         step();
         check("idle_os1", output_spikes1, '0);
         check("idle_os2", output_spikes2, '0);
         check("idle_st", {spike_time2, spike_time1}, 16'h9999);
      end

      // basic demux
      clear_pat(); pulse(0, 3, 8); pulse(1, 12, 17);
      push(8'h93, 2'b01, 8'h39, 2'b10);
      run_cycle(1'b1, 0, 0);

      // boundary offsets
      clear_pat(); pulse(0, 0, 0); pulse(1, 8, 8);
      push(8'h80, 2'b11, 8'h99, 2'b00);
      run_cycle(1'b0, 0, 0);
      clear_pat(); pulse(0, 9, 9); pulse(1, 17, 17);
      push(8'h99, 2'b00, 8'h80, 2'b11);
      run_cycle(1'b0, 0, 0);

      // level held across the slot boundary
      clear_pat(); pulse(0, 5, 12);
      push(8'h95, 2'b01, 8'h90, 2'b01);
      run_cycle(1'b0, 0, 0);

      for (int unsigned i = 0; i < 3; i++) begin
         rand_pat(); push_model();
         run_cycle(1'b0, 0, 0);
      end

      // misaligned restart at counter 10
      check("aerr_before", align_err, 1'b0);
      rand_pat();
      run_cycle(1'b0, 1, 10);
      check("aerr_set", align_err, 1'b1);
      rand_pat(); push_model();
      run_cycle(1'b0, 0, 0);
      check("aerr_sticky", align_err, 1'b1);

      // async reset at counter 7 with captures pending
      clear_pat(); pulse(0, 2, 4); pulse(1, 0, 6);
      run_cycle(1'b0, 2, 7);
      col_spikes = 2'b11;
      for (int unsigned i = 0; i < 20; i++) begin
         step();
         check("post_reset_os1", output_spikes1, '0);
      end
      rand_pat(); push_model();
      run_cycle(1'b1, 0, 0);

      col_spikes = '0;
      repeat (3) step();
      check("sb_drained", 64'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/column_spike_demux.md
Name: column_spike_demux

Overview:
- Downstream of the multiplexed column.
- Each gamma cycle is split into two equal slots: slot 0 carries network 1 and slot 1 carries network 2. The column's shared output_spikes bus is time-shared across those slots.
- This block separates the shared bus into per-network spike streams.
- It also captures each neuron's first-spike time per network and publishes both result sets once per gamma cycle for the readout and STDP-monitor logic.

Parameters:
- Q, 2, number of column neurons (width of the spike bus).
- GAMMA_CYCLE_LENGTH, 18, clk cycles per gamma cycle; must be even and at least 4.
- SLOT_LENGTH, GAMMA_CYCLE_LENGTH/2, localparam; clk cycles per network slot.
- TW, $clog2(SLOT_LENGTH+1), localparam; width of the spike-time field.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rstb  input  1  asynchronous, active-high reset.
- grst  input  1  gamma reset/phase reference; sampled synchronously on clk; a rising edge marks gamma-cycle start.
- col_spikes  input  Q  output_spikes of the multiplexed column.
- output_spikes1  output  Q  network-1 spike stream.
- output_spikes2  output  Q  network-2 spike stream.
- spike_time1  output  [Q][TW]  per-neuron first-spike offset in slot 0; NO_SPIKE if none.
- spike_time2  output  [Q][TW]  the same for slot 1.
- hit1  output  Q  neuron fired in slot 0 of the published cycle.
- hit2  output  Q  neuron fired in slot 1 of the published cycle.
- result_valid  output  1  one-clk pulse when spike_time*/hit* update.
- align_err  output  1  sticky flag: grst edge arrived mid-cycle.

Behaviour:
- Reset (async, rstb=1): running=0, counter=0, grst_q=0, all spike outputs 0, hit*=0, spike_time*=NO_SPIKE (=SLOT_LENGTH), result_valid=0, align_err=0, all capture registers cleared.
- gamma_start = grst & ~grst_q, where grst_q is grst registered on clk.
- On the edge sampling gamma_start=1: counter<=0, running<=1. The cycle following that edge is counter 0.
- While running, counter increments each clk and wraps from GAMMA_CYCLE_LENGTH-1 to 0.
- Before the first gamma_start (running=0), col_spikes is ignored and all outputs hold their reset values.
- slot = (counter >= SLOT_LENGTH); offset = counter - slot*SLOT_LENGTH.
- Stream outputs (1-clk latency): on each edge, output_spikes1 <= (running && slot==0) ? col_spikes : 0, and output_spikes2 <= (running && slot==1) ? col_spikes : 0.
- Spike event for neuron q: col_spikes[q]=1 and either prev[q]=0 or offset==0.
  - prev is col_spikes registered.
  - A level already high at slot start therefore counts as an event at offset 0.
- Capture: the first event per neuron per slot stores offset into cap_time[slot][q] and sets cap_hit[slot][q]. Later events in the same slot are ignored.
- Publish, on the edge where counter==GAMMA_CYCLE_LENGTH-1:
  - spike_time*/hit* <= capture registers, including any event at this final counter value.
  - Neurons with no hit publish NO_SPIKE.
  - result_valid=1 during the next clk only.
  - Capture registers clear on the same edge.
- gamma_start while counter==GAMMA_CYCLE_LENGTH-1: identical to a normal wrap; publish occurs and no error is flagged.
- gamma_start at any other counter while running:
  - The in-progress cycle is abandoned: no publish, capture registers cleared, counter<=0.
  - align_err<=1; it clears only on rstb.
- gamma_start when grst is held high continuously does not occur: edge detect only.
- Reset asserted mid-cycle: everything returns to reset values immediately. Nothing is published until the next gamma_start and a full cycle.
- Published values hold until the next publish.

Decomposition:
- Package column_demux_pkg: function slot_length(g), NO_SPIKE constant function, typedef enum logic {SLOT_NET1, SLOT_NET2} slot_e, spike-time typedef parameterised via TW.
- Sub-module gamma_phase_tracker: grst edge detect, running flag, counter, slot/offset decode, last_cycle and misalign strobes.
- column_spike_demux instantiates gamma_phase_tracker and adds the capture, stream and publish logic.

Test Plan:
- Reset then idle: col_spikes=2'b11 with no grst edge -> all outputs stay 0, spike_time*=9, result_valid never pulses.
- Basic demux, default parameters: grst rise sampled at edge E0; col_spikes[0] rises at counter 3 and col_spikes[1] at counter 12 -> output_spikes1[0] high from counter 4; output_spikes2[1] high from counter 13; at counter 0 of the next cycle result_valid=1 with spike_time1={NO_SPIKE,3}, hit1=2'b01, spike_time2={3,NO_SPIKE}, hit2=2'b10.
- Boundary offsets: spikes at counter 0, 8, 9 and 17 -> spike_time1=0 for the counter-0 spike; a spike rising at counter 8 publishes 8; spike_time2=0 for the counter-9 spike; a spike rising at counter 17 publishes 8.
- Held level across the slot boundary: col_spikes[0] high from counter 5 through 12 -> spike_time1[0]=5, spike_time2[0]=0, both hits set.
- Misalignment: second grst rise sampled at counter 10 -> no result_valid for that cycle, align_err=1; the next full 18-clk cycle publishes correctly with align_err still 1.
- Async reset at counter 7 with captures pending -> outputs return to reset values immediately; no publish occurs until a new grst edge plus a full cycle.
